core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 190 +++++++++++++++++++
 tb/tb_core_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, emits datapath strobes, traps on unsupported
// opcodes and memory-ack timeouts, and counts retired instructions.
module core_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic [31:0] Instruction,
  output logic        IMem_Req,
  input  logic        IMem_Ack,
  output logic        DMem_Req,
  output logic        DMem_We,
  input  logic        DMem_Ack,
  output logic        IR_Wr_En,
  output logic        PC_Wr_En,
  output logic        Reg_Wr_En,
  output logic [2:0]  State,
  output logic        Illegal_Instr,
  output logic        Bus_Err,
  output logic [31:0] Instr_Retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Last request cycle index (counter counts completed wait cycles from 0).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [6:0]  r_opcode;
  logic [4:0]  r_rd;
  logic        r_illegal;
  logic        r_bus_err;
  logic [31:0] r_retired;
  logic [15:0] r_tmo;

  state_t      w_next;
  logic        w_imem_req;
  logic        w_ir_wr;
  logic        w_dmem_req;
  logic        w_dmem_we;
  logic        w_pc_wr;
  logic        w_reg_wr;
  logic        w_set_illegal;
  logic        w_set_bus_err;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_legal;
  logic        w_tmo_last;
  logic        w_unused;

  // Only opcode and rd are kept; the rest of the word belongs to the datapath.
  assign w_unused = ^Instruction[31:12];

  assign w_is_load   = (r_opcode == OP_LOAD);
  assign w_is_store  = (r_opcode == OP_STORE);
  assign w_is_branch = (r_opcode == OP_BRANCH);
  assign w_legal     = (r_opcode == OP_ALU)    || (r_opcode == OP_ALUI)  ||
                       (r_opcode == OP_LOAD)   || (r_opcode == OP_STORE) ||
                       (r_opcode == OP_BRANCH) || (r_opcode == OP_JALR)  ||
                       (r_opcode == OP_JAL)    || (r_opcode == OP_LUI)   ||
                       (r_opcode == OP_AUIPC);
  assign w_tmo_last  = (r_tmo == TMO_LAST);

  // Next-state and strobe decode from current state plus the relevant ack.
  always_comb begin
    w_next        = r_state;
    w_imem_req    = 1'b0;
    w_ir_wr       = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_pc_wr       = 1'b0;
    w_reg_wr      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (IMem_Ack) begin
          w_ir_wr = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_tmo_last) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next = ST_MEM;
        end else if (w_is_branch) begin
          w_pc_wr = 1'b1;
          w_next  = ST_FETCH;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        if (DMem_Ack) begin
          if (w_is_store) begin
            w_pc_wr = 1'b1;
            w_next  = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_tmo_last) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_TRAP;
        end
      end
      ST_WB: begin
        w_pc_wr  = 1'b1;
        w_reg_wr = (r_rd != 5'd0);
        w_next   = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_TRAP;
    endcase
  end

  // State, latched opcode/rd, sticky flags, retire and timeout counters.
  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      r_state   <= ST_IDLE;
      r_opcode  <= 7'd0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= 32'd0;
      r_tmo     <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_ir_wr) begin
        r_opcode <= Instruction[6:0];
        r_rd     <= Instruction[11:7];
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_pc_wr)       r_retired <= r_retired + 32'd1;
      // Restart on any state change so each FETCH/MEM visit times out afresh.
      if ((w_next != r_state) || ((r_state != ST_FETCH) && (r_state != ST_MEM)))
        r_tmo <= 16'd0;
      else
        r_tmo <= r_tmo + 16'd1;
    end
  end

  // Strobes are forced low while reset is asserted, whatever the old state.
  assign IMem_Req      = Rst_N & w_imem_req;
  assign IR_Wr_En      = Rst_N & w_ir_wr;
  assign DMem_Req      = Rst_N & w_dmem_req;
  assign DMem_We       = Rst_N & w_dmem_we;
  assign PC_Wr_En      = Rst_N & w_pc_wr;
  assign Reg_Wr_En     = Rst_N & w_reg_wr;
  assign State         = r_state;
  assign Illegal_Instr = r_illegal;
  assign Bus_Err       = r_bus_err;
  assign Instr_Retired = r_retired;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq. Each scenario queues per-cycle
// stimulus with the expected state/strobes/flags/count, then drains the queue.
module tb_core_seq;

  logic        Clk = 1'b0;
  logic        Rst_N = 1'b0;
  logic [31:0] Instruction = 32'd0;
  logic        IMem_Ack = 1'b0;
  logic        DMem_Ack = 1'b0;
  logic        IMem_Req, DMem_Req, DMem_We, IR_Wr_En, PC_Wr_En, Reg_Wr_En;
  logic [2:0]  State;
  logic        Illegal_Instr, Bus_Err;
  logic [31:0] Instr_Retired;

  core_seq #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Instruction(Instruction),
    .IMem_Req(IMem_Req), .IMem_Ack(IMem_Ack),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Ack(DMem_Ack),
    .IR_Wr_En(IR_Wr_En), .PC_Wr_En(PC_Wr_En), .Reg_Wr_En(Reg_Wr_En),
    .State(State), .Illegal_Instr(Illegal_Instr), .Bus_Err(Bus_Err),
    .Instr_Retired(Instr_Retired)
  );

  always #5 Clk = ~Clk;

  // Strobe groups: {IMem_Req, IR_Wr_En, DMem_Req, DMem_We, PC_Wr_En, Reg_Wr_En}
  localparam logic [5:0] NONE     = 6'b000000;
  localparam logic [5:0] F_WAIT   = 6'b100000;
  localparam logic [5:0] F_ACK    = 6'b110000;
  localparam logic [5:0] M_LD     = 6'b001000;
  localparam logic [5:0] M_ST     = 6'b001100;
  localparam logic [5:0] M_ST_ACK = 6'b001110;
  localparam logic [5:0] PC_ONLY  = 6'b000010;
  localparam logic [5:0] WB_REG   = 6'b000011;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00000013;
  localparam logic [31:0] I_LUI  = 32'h000010B7;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct packed {
    logic        rst_n;
    logic        ia;
    logic        da;
    logic [31:0] instr;
    logic [42:0] exp;
  } rec_t;

  rec_t        sb_q[$];
  rec_t        rec;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_cyc;
  logic [31:0] m_ret = 32'd0;
  logic        m_ill = 1'b0;
  logic        m_berr = 1'b0;
  logic [42:0] w_obs;

  assign w_obs = {State, IMem_Req, IR_Wr_En, DMem_Req, DMem_We, PC_Wr_En,
                  Reg_Wr_En, Illegal_Instr, Bus_Err, Instr_Retired};

  // Queue one cycle: inputs plus expected outputs from the bench's own model.
  function automatic void push(input logic rst_n, input logic ia, input logic da,
                               input logic [31:0] instr, input logic [2:0] st,
                               input logic [5:0] sb);
    rec_t r;
    r.rst_n = rst_n;
    r.ia    = ia;
    r.da    = da;
    r.instr = instr;
    r.exp   = {st, sb, m_ill, m_berr, m_ret};
    sb_q.push_back(r);
    if (!rst_n) begin
      m_ret  = 32'd0;
      m_ill  = 1'b0;
      m_berr = 1'b0;
    end else if (sb[1]) begin
      m_ret = m_ret + 32'd1;
    end
  endfunction

  task automatic test_reset();
    Rst_N = 1'b0; IMem_Ack = 1'b1; DMem_Ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      n_checks++;
      if (w_obs[39:34] !== NONE) begin
        n_errors++;
        $display("FAIL reset_strobes: got %b expected %b", w_obs[39:34], NONE);
      end
      @(posedge Clk); #1;
    end
    Rst_N = 1'b1; IMem_Ack = 1'b0; DMem_Ack = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (w_obs !== 43'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", w_obs, 43'd0);
    end
    @(posedge Clk); #1;
    $display("test_reset: IDLE with flags and count cleared");
  endtask

  task automatic test_alu();
    push(1, 1, 0, I_ADD, 3'd1, F_ACK);   push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd5, WB_REG);
    push(1, 0, 0, 0, 3'd1, F_WAIT);      push(1, 1, 0, I_ADDI, 3'd1, F_ACK);
    push(1, 0, 0, 0, 3'd2, NONE);        push(1, 0, 0, 0, 3'd3, NONE);
    push(1, 0, 0, 0, 3'd5, PC_ONLY);
    push(1, 1, 0, I_LUI, 3'd1, F_ACK);   push(1, 1, 0, I_BAD, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd5, WB_REG);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL alu cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_alu: ADD/ADDI x0/LUI, %0d cycles, retired model %0d", n_cyc, m_ret);
  endtask

  task automatic test_mem();
    push(1, 1, 1, I_LW, 3'd1, F_ACK);    push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd4, M_LD);
    push(1, 1, 0, 0, 3'd4, M_LD);        push(1, 0, 0, 0, 3'd4, M_LD);
    push(1, 0, 1, 0, 3'd4, M_LD);        push(1, 0, 0, 0, 3'd5, WB_REG);
    push(1, 1, 0, I_SW, 3'd1, F_ACK);    push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 1, 0, 0, 3'd3, NONE);        push(1, 0, 1, 0, 3'd4, M_ST_ACK);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL mem cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_mem: LW (ack 4th cycle) and SW, %0d cycles, retired model %0d", n_cyc, m_ret);
  endtask

  task automatic test_branch();
    push(1, 1, 0, I_BEQ, 3'd1, F_ACK);   push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, PC_ONLY);
    push(1, 1, 0, I_JAL, 3'd1, F_ACK);   push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd5, WB_REG);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL branch cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_branch: BEQ and JAL, %0d cycles, retired model %0d", n_cyc, m_ret);
  endtask

  task automatic test_timeout();
    // Fetch ack arriving in the last allowed cycle still proceeds.
    for (int i = 0; i < 3; i++) push(1, 0, 0, 0, 3'd1, F_WAIT);
    push(1, 1, 0, I_ADD, 3'd1, F_ACK);   push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd5, WB_REG);
    // Store whose data ack never comes.
    push(1, 1, 0, I_SW, 3'd1, F_ACK);    push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);
    for (int i = 0; i < 4; i++) push(1, 0, 0, 0, 3'd4, M_ST);
    m_berr = 1'b1;
    push(1, 1, 1, 0, 3'd6, NONE);        push(1, 1, 1, 0, 3'd6, NONE);
    // Reset, then a fetch that is never acked.
    push(0, 0, 0, 0, 3'd6, NONE);        push(1, 0, 0, 0, 3'd0, NONE);
    for (int i = 0; i < 4; i++) push(1, 0, 0, 0, 3'd1, F_WAIT);
    m_berr = 1'b1;
    push(1, 1, 1, I_ADD, 3'd6, NONE);    push(1, 1, 1, 0, 3'd6, NONE);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL timeout cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_timeout: fetch ack at limit, data and fetch timeouts, %0d cycles", n_cyc);
  endtask

  task automatic test_illegal();
    push(0, 0, 0, 0, 3'd6, NONE);        push(1, 0, 0, 0, 3'd0, NONE);
    push(1, 1, 0, I_BAD, 3'd1, F_ACK);   push(1, 0, 0, 0, 3'd2, NONE);
    m_ill = 1'b1;
    for (int i = 0; i < 3; i++) push(1, 1, 1, I_ADD, 3'd6, NONE);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL illegal cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_illegal: opcode 0x7F traps, %0d cycles", n_cyc);
  endtask

  task automatic test_reset_mid();
    push(0, 0, 0, 0, 3'd6, NONE);        push(1, 0, 0, 0, 3'd0, NONE);
    push(1, 1, 0, I_ADDI, 3'd1, F_ACK);  push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd5, PC_ONLY);
    push(1, 1, 0, I_LW, 3'd1, F_ACK);    push(1, 0, 0, 0, 3'd2, NONE);
    push(1, 0, 0, 0, 3'd3, NONE);        push(1, 0, 0, 0, 3'd4, M_LD);
    push(0, 0, 1, 0, 3'd4, NONE);        push(1, 0, 1, 0, 3'd0, NONE);
    push(1, 0, 0, 0, 3'd1, F_WAIT);
    n_cyc = 0;
    while (sb_q.size() > 0) begin
      rec = sb_q.pop_front();
      Rst_N = rec.rst_n; IMem_Ack = rec.ia; DMem_Ack = rec.da; Instruction = rec.instr;
      @(negedge Clk);
      n_checks++;
      if (w_obs !== rec.exp) begin
        n_errors++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", n_cyc, w_obs, rec.exp);
      end
      n_cyc++;
      @(posedge Clk); #1;
    end
    $display("test_reset_mid: reset during MEM aborts access, %0d cycles", n_cyc);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
